// File: rtl/pool_layer_1_pkg.sv
// pool_layer_1_pkg: shared layer-1 geometry and a counter-width helper.
package pool_layer_1_pkg;
    localparam int CONV1_OUT_W = 26;
    localparam int CONV1_OUT_H = 26;
    localparam int POOL1_OUT_W = 13;
    localparam int POOL1_OUT_H = 13;
    localparam int CONV1_CH    = 8;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pool1_line_buf.sv
// pool1_line_buf: one row of half-window ORs, synchronous write, combinational read.
module pool1_line_buf #(
    parameter int CH    = 8,
    parameter int DEPTH = 13,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [CH-1:0] wdata,
    output logic [CH-1:0] rdata
);
    logic [CH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/pool_layer_1.sv
// pool_layer_1: streaming 2x2 binary max-pool over a raster-ordered CH-channel feature map.
module pool_layer_1
    import pool_layer_1_pkg::*;
#(
    parameter int IN_WIDTH  = CONV1_OUT_W,
    parameter int IN_HEIGHT = CONV1_OUT_H,
    parameter int CH        = CONV1_CH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_in,
    input  logic [CH-1:0] conv1_in,
    output logic [CH-1:0] pool1_out,
    output logic          valid_out_pool1,
    output logic          frame_done
);
    localparam int CW    = cnt_w(IN_WIDTH);
    localparam int RW    = cnt_w(IN_HEIGHT);
    localparam int DEPTH = IN_WIDTH / 2;
    localparam int AW    = cnt_w(DEPTH);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CH-1:0] acc, lb_rdata;
    logic          col_last, row_last, in_win, lb_we, fire;

    // Trailing odd column/row sits outside every window (floor pooling).
    always_comb begin
        col_last = col == COL_LAST;
        row_last = row == ROW_LAST;
        in_win   = ((IN_WIDTH % 2 == 0) || !col_last) && ((IN_HEIGHT % 2 == 0) || !row_last);
        lb_we    = valid_in && in_win && !row[0] && col[0];
        fire     = valid_in && in_win && row[0] && col[0];
    end

    pool1_line_buf #(.CH(CH), .DEPTH(DEPTH), .AW(AW)) u_line_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lb_we),
        .addr  (AW'(col >> 1)),
        .wdata (acc | conv1_in),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col             <= '0;
            row             <= '0;
            acc             <= '0;
            pool1_out       <= '0;
            valid_out_pool1 <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            valid_out_pool1 <= fire;
            frame_done      <= valid_in && col_last && row_last;
            if (valid_in) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last) row <= row_last ? '0 : row + 1'b1;
            end
            if (valid_in && in_win && !col[0]) acc <= row[0] ? (conv1_in | lb_rdata) : conv1_in;
            if (fire) pool1_out <= acc | conv1_in;
        end
    end
endmodule

// File: doc/pool_layer_1.md
POOL_LAYER_1 -- requirements
Module: pool_layer_1

Interface
REQ-001 Parameter IN_WIDTH, default 26, columns per input feature-map row.
REQ-002 Parameter IN_HEIGHT, default 26, rows per input feature map.
REQ-003 Parameter CH, default 8, channel count, one bit per channel per beat.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 valid_in  input  1  beat qualifier; conv1_in is sampled only when high.
REQ-007 conv1_in  input  CH  one binary conv-1 output per channel; bit k-1 = channel k.
REQ-008 pool1_out  output  CH  pooled 2x2 result per channel, registered.
REQ-009 valid_out_pool1  output  1  one-cycle pulse qualifying pool1_out.
REQ-010 frame_done  output  1  one-cycle pulse after the final pooled beat of a frame.

Function
REQ-011 Input beats shall arrive in raster order; idle cycles (valid_in low) may occur anywhere and shall not change state.
REQ-012 Column counter col (0..IN_WIDTH-1) shall increment on each accepted beat and wrap to 0, incrementing row counter row (0..IN_HEIGHT-1), which wraps to 0 at frame end.
REQ-013 Pooling is binary max: output bit = OR of the 4 window bits for window (2i..2i+1, 2j..2j+1), per channel independently.
REQ-014 Even row, even col: horizontal accumulator acc <= conv1_in.
REQ-015 Even row, odd col: line buffer entry [col>>1] <= acc | conv1_in.
REQ-016 Odd row, even col: acc <= conv1_in | line buffer[col>>1].
REQ-017 Odd row, odd col: pool1_out <= acc | conv1_in and valid_out_pool1 pulses high for exactly one cycle on the next edge (latency 1 cycle from the completing beat).
REQ-018 Line buffer shall hold IN_WIDTH/2 entries of CH bits; each entry is written once per row pair.
REQ-019 If IN_WIDTH or IN_HEIGHT is odd, the trailing column/row shall still advance counters but shall never produce output (floor pooling).
REQ-020 Per frame exactly (IN_WIDTH/2)*(IN_HEIGHT/2) output pulses shall occur (169 with defaults).
REQ-021 frame_done shall pulse one cycle after the beat at (IN_HEIGHT-1, IN_WIDTH-1) is accepted, coincident with the last valid_out_pool1 when dimensions are even.
REQ-022 pool1_out shall hold its last value between pulses.
REQ-023 Back-to-back frames with no idle gap shall be pooled correctly; the counter wrap alone delimits frames.

Reset
REQ-024 On rst_n low: col, row, acc, line buffer, pool1_out, valid_out_pool1, frame_done all cleared to 0 immediately.
REQ-025 Reset asserted mid-frame shall discard the partial frame; the first beat after release is treated as (0,0).
REQ-026 A beat coincident with the first rising edge after rst_n release shall be accepted.

Structure
REQ-027 Shared package shall hold CONV1_OUT_W=26, CONV1_OUT_H=26, POOL1_OUT_W=13, POOL1_OUT_H=13, CONV1_CH=8.
REQ-028 The line buffer shall be a sub-module pool1_line_buf (synchronous write, combinational read, CH x IN_WIDTH/2); counters and control stay in pool_layer_1.

Verification
REQ-029 All-zero frame, 676 contiguous beats -> 169 pulses, pool1_out=0x00 each, frame_done once after beat 676.
REQ-030 Single 1 on ch 3 at (row 5, col 10) only -> only window (2,5) outputs 0x04; all other 168 outputs 0x00.
REQ-031 Channel k high only at window-corner (2i+1, 2j+1) for all windows, k=1..8 -> every output 0xFF.
REQ-032 Random valid_in gaps (50% duty) with random data -> outputs match reference model bit-exactly, count 169.
REQ-033 Reset asserted at beat 300, then full clean frame -> no output from partial frame, clean frame yields 169 correct outputs.
REQ-034 Two frames back-to-back, IN_WIDTH=IN_HEIGHT=5 override -> 4 pulses per frame, row/col 4 ignored, frame_done after beats 25 and 50.
